// File: rtl/usbh_defs_pkg.sv
`default_nettype none
// ============================================================================
// Module  : usbh_defs (package)
// Brief   : Shared USB host definitions: PIDs, CRC16 constants, TX FSM states
// Revision: 1.0
// ============================================================================
package usbh_defs;

  localparam logic [7:0] PID_DATA0 = 8'hC3;
  localparam logic [7:0] PID_DATA1 = 8'h4B;
  localparam logic [7:0] PID_DATA2 = 8'h87;
  localparam logic [7:0] PID_MDATA = 8'h0F;

  localparam logic [15:0] CRC16_POLY     = 16'hA001;
  localparam logic [15:0] CRC16_INIT     = 16'hFFFF;
  localparam logic [15:0] CRC16_RESIDUAL = 16'hB001;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_PID    = 3'd1,
    ST_DATA   = 3'd2,
    ST_CRC_LO = 3'd3,
    ST_CRC_HI = 3'd4
  } tx_state_t;

endpackage
`default_nettype wire

// File: rtl/usbh_crc16.sv
`default_nettype none
// ============================================================================
// Module  : usbh_crc16
// Brief   : One-byte combinational CRC16 step, reflected 0xA001, LSB first
// Revision: 1.0
// ============================================================================
module usbh_crc16
  import usbh_defs::*;
(
  input  logic [15:0] crc_in,
  input  logic [7:0]  data_in,
  output logic [15:0] crc_out
);

  logic [15:0] crc_acc;

  always_comb begin
    crc_acc = crc_in;
    for (int i = 0; i < 8; i++) begin
      if (crc_acc[0] ^ data_in[i]) begin
        crc_acc = (crc_acc >> 1) ^ CRC16_POLY;
      end else begin
        crc_acc = crc_acc >> 1;
      end
    end
    crc_out = crc_acc;
  end

endmodule
`default_nettype wire

// File: rtl/usbh_tx_data.sv
`default_nettype none
// ============================================================================
// Module  : usbh_tx_data
// Brief   : USB FS host DATA packet transmitter: PID, FIFO payload, CRC16 to UTMI
// Revision: 1.0
// ============================================================================
module usbh_tx_data
  import usbh_defs::*;
#(
  parameter int LEN_W = 11
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [7:0]       pid_i,
  input  logic [LEN_W-1:0] len_i,
  input  logic             abort_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             underrun_o,
  input  logic [7:0]       fifo_data_i,
  input  logic             fifo_empty_i,
  output logic             fifo_pop_o,
  output logic [7:0]       utmi_data_o,
  output logic             utmi_txvalid_o,
  input  logic             utmi_txready_i
);

  tx_state_t        state;
  logic [7:0]       pid;
  logic [LEN_W-1:0] count;
  logic [15:0]      crc;
  logic [15:0]      crc_next;
  logic             done;
  logic             accept;

  usbh_crc16 u_crc16 (
    .crc_in  (crc),
    .data_in (fifo_data_i),
    .crc_out (crc_next)
  );

  // Payload bytes come straight from the FIFO head so txvalid can track emptiness
  always_comb begin
    utmi_data_o    = 8'h00;
    utmi_txvalid_o = 1'b0;
    case (state)
      ST_PID: begin
        utmi_data_o    = pid;
        utmi_txvalid_o = 1'b1;
      end
      ST_DATA: begin
        utmi_data_o    = fifo_data_i;
        utmi_txvalid_o = !fifo_empty_i;
      end
      ST_CRC_LO: begin
        utmi_data_o    = ~crc[7:0];
        utmi_txvalid_o = 1'b1;
      end
      ST_CRC_HI: begin
        utmi_data_o    = ~crc[15:8];
        utmi_txvalid_o = 1'b1;
      end
      default: begin
        utmi_data_o    = 8'h00;
        utmi_txvalid_o = 1'b0;
      end
    endcase
  end

  assign accept     = utmi_txvalid_o && utmi_txready_i;
  assign fifo_pop_o = (state == ST_DATA) && !fifo_empty_i && utmi_txready_i;
  assign underrun_o = (state == ST_DATA) && fifo_empty_i && !abort_i;
  assign busy_o     = (state != ST_IDLE);
  assign done_o     = done;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state <= ST_IDLE;
      pid   <= 8'h00;
      count <= '0;
      crc   <= CRC16_INIT;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      if (abort_i) begin
        state <= ST_IDLE;
      end else begin
        case (state)
          ST_IDLE: begin
            if (start_i) begin
              pid   <= pid_i;
              count <= len_i;
              crc   <= CRC16_INIT;
              state <= ST_PID;
            end
          end
          ST_PID: begin
            if (accept) begin
              state <= (count != '0) ? ST_DATA : ST_CRC_LO;
            end
          end
          ST_DATA: begin
            if (fifo_empty_i) begin
              state <= ST_IDLE;
            end else if (accept) begin
              crc <= crc_next;
              if (count != '0) begin
                count <= count - LEN_W'(1);
              end
              if (count <= LEN_W'(1)) begin
                state <= ST_CRC_LO;
              end
            end
          end
          ST_CRC_LO: begin
            if (accept) begin
              state <= ST_CRC_HI;
            end
          end
          ST_CRC_HI: begin
            if (accept) begin
              state <= ST_IDLE;
              done  <= 1'b1;
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule
`default_nettype wire
